// File: rtl/map_cfg_sequencer_if.sv
// Bus bundle between the MCU-side config port and the mapper reconfiguration sequencer.
// The MCU drives the master side; the sequencer implements the slave side.
interface map_cfg_sequencer_if #(
  parameter int CFG_BYTES = 8
);
  logic                   cfg_we;
  logic [2:0]             cfg_addr;
  logic [7:0]             cfg_di;
  logic                   commit;
  logic                   abort;
  logic                   m2;
  logic [CFG_BYTES*8-1:0] cfg_active;
  logic [7:0]             map_idx;
  logic                   map_known;
  logic                   mapper_rst;
  logic                   busy;
  logic                   commit_done;
  logic                   cfg_err;

  modport master (
    output cfg_we, cfg_addr, cfg_di, commit, abort, m2,
    input  cfg_active, map_idx, map_known, mapper_rst, busy, commit_done, cfg_err
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_di, commit, abort, m2,
    output cfg_active, map_idx, map_known, mapper_rst, busy, commit_done, cfg_err
  );
endinterface

// File: rtl/map_cfg_sequencer.sv
// Applies a shadowed mapper configuration atomically: waits for a quiet CPU bus,
// holds the mapper array in reset, swaps the active word, then releases it.
module map_cfg_sequencer #(
  parameter int CFG_BYTES = 8,
  parameter int IDLE_CYC  = 4,
  parameter int HOLD_CYC  = 16
) (
  input  logic                      clk,
  input  logic                      map_rst,
  map_cfg_sequencer_if.slave        bus
);

  localparam int IW = (IDLE_CYC > 1) ? $clog2(IDLE_CYC) : 1;
  localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYC - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_IDLE,
    ST_HOLD,
    ST_SWAP,
    ST_RELEASE
  } state_t;

  state_t                 r_state;
  logic [IW-1:0]          r_idle_cnt;
  logic [HW-1:0]          r_hold_cnt;
  logic [CFG_BYTES*8-1:0] r_cfg_active;
  logic                   r_map_known;
  logic                   r_mapper_rst;
  logic                   r_busy;
  logic                   r_commit_done;
  logic                   r_cfg_err;

  logic                   w_idle;
  logic [CFG_BYTES*8-1:0] w_shadow_flat;

  assign w_idle = (r_state == ST_IDLE);

  function automatic logic is_known(input logic [7:0] idx);
    case (idx)
      8'd12, 8'd47, 8'd64, 8'd74, 8'd115, 8'd118, 8'd119,
      8'd158, 8'd182, 8'd189, 8'd191, 8'd196, 8'd205, 8'd245: is_known = 1'b1;
      default:                                               is_known = 1'b0;
    endcase
  endfunction

  // Shadow bytes only accept writes while no commit is in flight.
  genvar gi;
  generate
    for (gi = 0; gi < CFG_BYTES; gi++) begin : g_shadow
      logic [7:0] r_byte;
      always_ff @(posedge clk) begin
        if (map_rst) begin
          r_byte <= '0;
        end else if (w_idle && bus.cfg_we && ({29'd0, bus.cfg_addr} == 32'(gi))) begin
          r_byte <= bus.cfg_di;
        end
      end
      assign w_shadow_flat[gi*8 +: 8] = r_byte;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (map_rst) begin
      r_state       <= ST_IDLE;
      r_idle_cnt    <= '0;
      r_hold_cnt    <= '0;
      r_cfg_active  <= '0;
      r_map_known   <= 1'b0;
      r_mapper_rst  <= 1'b0;
      r_busy        <= 1'b0;
      r_commit_done <= 1'b0;
      r_cfg_err     <= 1'b0;
    end else begin
      r_commit_done <= 1'b0;
      if (!w_idle && (bus.cfg_we || bus.commit)) begin
        r_cfg_err <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (bus.commit) begin
            r_state    <= ST_WAIT_IDLE;
            r_busy     <= 1'b1;
            r_cfg_err  <= 1'b0;
            r_idle_cnt <= '0;
          end
        end
        ST_WAIT_IDLE: begin
          if (bus.abort) begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_idle_cnt <= '0;
          end else if (bus.m2) begin
            r_idle_cnt <= '0;
          end else if (r_idle_cnt == IDLE_LAST) begin
            r_state      <= ST_HOLD;
            r_mapper_rst <= 1'b1;
            r_hold_cnt   <= '0;
          end else begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
          end
        end
        ST_HOLD: begin
          if (r_hold_cnt == HOLD_LAST) begin
            r_state <= ST_SWAP;
          end else begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end
        ST_SWAP: begin
          // map_known is decoded from the incoming word so it lands with map_idx.
          r_state       <= ST_RELEASE;
          r_mapper_rst  <= 1'b0;
          r_commit_done <= 1'b1;
          r_cfg_active  <= w_shadow_flat;
          r_map_known   <= is_known(w_shadow_flat[7:0]);
        end
        ST_RELEASE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state      <= ST_IDLE;
          r_busy       <= 1'b0;
          r_mapper_rst <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cfg_active  = r_cfg_active;
  assign bus.map_idx     = r_cfg_active[7:0];
  assign bus.map_known   = r_map_known;
  assign bus.mapper_rst  = r_mapper_rst;
  assign bus.busy        = r_busy;
  assign bus.commit_done = r_commit_done;
  assign bus.cfg_err     = r_cfg_err;

endmodule

// File: tb/tb_map_cfg_sequencer.sv
// Directed bench for map_cfg_sequencer: a cycle-scheduled model checks every output
// each cycle, and literal expectations pin latencies and key values.
module tb_map_cfg_sequencer;

  localparam int CFG_BYTES = 8;
  localparam int IDLE_CYC  = 4;
  localparam int HOLD_CYC  = 16;

  logic clk = 1'b0;
  logic map_rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  map_cfg_sequencer_if #(.CFG_BYTES(CFG_BYTES)) bus ();

  map_cfg_sequencer #(
    .CFG_BYTES(CFG_BYTES),
    .IDLE_CYC (IDLE_CYC),
    .HOLD_CYC (HOLD_CYC)
  ) dut (
    .clk    (clk),
    .map_rst(map_rst),
    .bus    (bus.slave)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a commit is either waiting for a quiet bus (mode 1) or scheduled in
  // absolute cycles from the cycle its reset hold begins (mode 2).
  int          known_list [14] = '{12, 47, 64, 74, 115, 118, 119, 158, 182, 189, 191, 196, 205, 245};
  logic [7:0]  m_shadow [CFG_BYTES];
  logic [63:0] m_active;
  logic        m_err;
  int          m_mode;
  int          m_low_run;
  int          m_hs;
  int          t = 0;

  function automatic logic known_of(input logic [7:0] v);
    logic k = 1'b0;
    for (int i = 0; i < 14; i++) if (int'(v) == known_list[i]) k = 1'b1;
    return k;
  endfunction

  always @(posedge clk) begin
    logic        was_busy;
    logic [63:0] flat;
    logic        e_rst;
    logic        e_done;
    t++;
    if (map_rst) begin
      for (int i = 0; i < CFG_BYTES; i++) m_shadow[i] = 8'h00;
      m_active  = '0;
      m_err     = 1'b0;
      m_mode    = 0;
      m_low_run = 0;
    end else begin
      was_busy = (m_mode != 0);
      if (m_mode == 1) begin
        if (bus.abort) m_mode = 0;
        else if (!bus.m2) begin
          m_low_run++;
          if (m_low_run == IDLE_CYC) begin
            m_mode = 2;
            m_hs   = t;
          end
        end else m_low_run = 0;
      end else if (m_mode == 2) begin
        if (t == m_hs + HOLD_CYC + 1) begin
          for (int i = 0; i < CFG_BYTES; i++) flat[i*8 +: 8] = m_shadow[i];
          m_active = flat;
        end
        if (t == m_hs + HOLD_CYC + 2) m_mode = 0;
      end
      if (!was_busy) begin
        if (bus.cfg_we && int'(bus.cfg_addr) < CFG_BYTES) m_shadow[bus.cfg_addr] = bus.cfg_di;
        if (bus.commit) begin
          m_mode    = 1;
          m_low_run = 0;
          m_err     = 1'b0;
        end
      end else if (bus.cfg_we || bus.commit) begin
        m_err = 1'b1;
      end
    end
    e_rst  = (m_mode == 2) && (t >= m_hs) && (t <= m_hs + HOLD_CYC);
    e_done = (m_mode == 2) && (t == m_hs + HOLD_CYC + 1);
    #1;
    chk("busy",        64'(bus.busy),        64'(m_mode != 0));
    chk("mapper_rst",  64'(bus.mapper_rst),  64'(e_rst));
    chk("commit_done", 64'(bus.commit_done), 64'(e_done));
    chk("cfg_active",  bus.cfg_active,       m_active);
    chk("map_idx",     64'(bus.map_idx),     64'(m_active[7:0]));
    chk("map_known",   64'(bus.map_known),   64'(known_of(m_active[7:0])));
    chk("cfg_err",     64'(bus.cfg_err),     64'(m_err));
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic write_byte(input logic [2:0] a, input logic [7:0] d);
    bus.cfg_we = 1'b1; bus.cfg_addr = a; bus.cfg_di = d;
    step();
    bus.cfg_we = 1'b0;
  endtask

  task automatic do_commit();
    bus.commit = 1'b1;
    step();
    bus.commit = 1'b0;
  endtask

  task automatic wait_done(input int start, output int n);
    n = start;
    while (!bus.commit_done && n < 200) begin
      step();
      n++;
    end
    chk("done_seen", 64'(bus.commit_done), 64'd1);
    $display("commit_done cycle=%0d map_idx=%0d map_known=%0d", n, bus.map_idx, bus.map_known);
  endtask

  task automatic no_done_for(input int cycles);
    int cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (bus.commit_done) cnt++;
    end
    chk("extra_done", 64'(cnt), 64'd0);
  endtask

  initial begin
    int n;
    map_rst = 1'b1;
    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_di = '0;
    bus.commit = 1'b0; bus.abort = 1'b0; bus.m2 = 1'b0;
    repeat (3) step();
    chk("rst_active", bus.cfg_active, 64'd0);
    chk("rst_busy",   64'(bus.busy),  64'd0);
    map_rst = 1'b0;
    step();

    // Load and commit with a quiet bus
    write_byte(3'd0, 8'h04);
    for (int i = 1; i < 8; i++) write_byte(3'(i), 8'h10 + 8'(i));
    do_commit();
    wait_done(1, n);
    chk("latency",     64'(n), 64'd22);
    chk("load_active", bus.cfg_active, 64'h1716151413121104);
    chk("load_known",  64'(bus.map_known), 64'd0);
    step();
    chk("busy_after",  64'(bus.busy), 64'd0);

    // Known mapper decode
    write_byte(3'd0, 8'd245); do_commit(); wait_done(1, n);
    chk("known_245", 64'(bus.map_known), 64'd1);
    chk("idx_245",   64'(bus.map_idx),   64'd245);
    step();
    write_byte(3'd0, 8'd158); do_commit(); wait_done(1, n);
    chk("known_158", 64'(bus.map_known), 64'd1);
    step();
    write_byte(3'd0, 8'd100); do_commit(); wait_done(1, n);
    chk("known_100", 64'(bus.map_known), 64'd0);
    step();

    // Bus activity keeps the sequencer waiting
    write_byte(3'd0, 8'd191);
    do_commit();
    for (int i = 0; i <= 20; i++) begin
      bus.m2 = (i % 3 == 2);
      step();
    end
    chk("wait_busy", 64'(bus.busy),       64'd1);
    chk("wait_nrst", 64'(bus.mapper_rst), 64'd0);
    bus.m2 = 1'b0;
    n = 1;
    while (!bus.mapper_rst && n < 50) begin
      step();
      n++;
    end
    chk("hold_5th_low", 64'(n), 64'd5);
    wait_done(n, n);
    chk("idx_191", 64'(bus.map_idx), 64'd191);
    step();

    // Abort while waiting, then abort ignored in HOLD
    write_byte(3'd0, 8'h55);
    do_commit();
    step();
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("abort_busy",   64'(bus.busy),    64'd0);
    chk("abort_active", 64'(bus.map_idx), 64'd191);
    step();
    do_commit();
    n = 1;
    while (n < 8) begin step(); n++; end
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    wait_done(9, n);
    chk("abort_hold_lat", 64'(n), 64'd22);
    chk("abort_hold_idx", 64'(bus.map_idx), 64'h55);
    step();

    // Rejected write and commit during HOLD
    write_byte(3'd0, 8'd47);
    do_commit();
    n = 1;
    while (n < 8) begin step(); n++; end
    bus.cfg_we = 1'b1; bus.cfg_addr = 3'd0; bus.cfg_di = 8'hAA;
    step();
    bus.cfg_we = 1'b0; bus.commit = 1'b1;
    step();
    bus.commit = 1'b0;
    wait_done(10, n);
    chk("rej_lat", 64'(n), 64'd22);
    chk("rej_idx", 64'(bus.map_idx), 64'd47);
    chk("rej_err", 64'(bus.cfg_err), 64'd1);
    no_done_for(30);
    do_commit();
    chk("err_clear", 64'(bus.cfg_err), 64'd0);
    wait_done(1, n);
    chk("rej_shadow", 64'(bus.map_idx), 64'd47);
    step();

    // Same-cycle write+commit, then reset mid-HOLD
    bus.cfg_we = 1'b1; bus.cfg_addr = 3'd0; bus.cfg_di = 8'h40; bus.commit = 1'b1;
    step();
    bus.cfg_we = 1'b0; bus.commit = 1'b0;
    wait_done(1, n);
    chk("same_idx", 64'(bus.map_idx), 64'h40);
    step();
    bus.cfg_we = 1'b1; bus.cfg_addr = 3'd0; bus.cfg_di = 8'h0C; bus.commit = 1'b1;
    step();
    bus.cfg_we = 1'b0; bus.commit = 1'b0;
    n = 1;
    while (n < 10) begin step(); n++; end
    map_rst = 1'b1;
    step();
    map_rst = 1'b0;
    chk("mid_rst_nrst",   64'(bus.mapper_rst), 64'd0);
    chk("mid_rst_active", bus.cfg_active,      64'd0);
    no_done_for(30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
